// File: rtl/m_cycle_sequencer.sv
// m_cycle_sequencer: one-hot T-step / M-cycle timing for the control unit, with CB-prefix and HALT state.
// Optional CYCLE_WATCHDOG_EN: M-cycle count overflow drops CB mode and sets a sticky o_Watchdog flag.
module m_cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Stall,
    input  logic       i_IR_Fetch,
    input  logic       i_CB_Set,
    input  logic       i_Disable_CB,
    input  logic       i_Halt,
    input  logic       i_Wake,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic       o_CB_Active,
    output logic       o_Halted,
    output logic       o_Step_End,
    output logic       o_Watchdog
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_step, w_step_nxt;
    logic [7:0] r_count, w_count_nxt;
    logic       r_cb, w_cb_nxt;

    assign o_Step_End    = r_step[3] & ~i_Stall;
    assign o_Cycle_Step  = r_step;
    assign o_Cycle_Count = r_count;
    assign o_CB_Active   = r_cb;
    assign o_Halted      = (r_state == S_HALT);

`ifdef CYCLE_WATCHDOG_EN
    logic w_overflow;
    logic r_wdog;
    assign w_overflow = o_Step_End & (r_state == S_RUN) & ~i_IR_Fetch & r_count[7];
    assign o_Watchdog = r_wdog;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            r_wdog <= 1'b0;
        else if (w_overflow)
            r_wdog <= 1'b1;
    end
`else
    assign o_Watchdog = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= S_RUN;
            r_step  <= 4'b0001;
            r_count <= 8'h01;
            r_cb    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_count <= w_count_nxt;
            r_cb    <= w_cb_nxt;
        end
    end

    // Every decision other than the step rotation happens only on the M-cycle boundary.
    always_comb begin
        w_step_nxt  = i_Stall ? r_step : {r_step[2:0], r_step[3]};
        w_count_nxt = r_count;
        w_cb_nxt    = r_cb;
        w_state_nxt = r_state;
        if (o_Step_End) begin
            if (r_state == S_HALT) begin
                w_count_nxt = 8'h01;
                if (i_Wake)
                    w_state_nxt = S_RUN;
            end else if (i_IR_Fetch) begin
                w_count_nxt = 8'h01;
                w_cb_nxt    = i_CB_Set | (r_cb & ~i_Disable_CB);
                if (i_Halt && !i_Wake)
                    w_state_nxt = S_HALT;
            end else begin
                w_count_nxt = {r_count[6:0], r_count[7]};
`ifdef CYCLE_WATCHDOG_EN
                if (r_count[7])
                    w_cb_nxt = 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_m_cycle_sequencer.sv
// tb_m_cycle_sequencer: directed and randomized checks of m_cycle_sequencer against an index-based reference model.
// Follows CYCLE_WATCHDOG_EN to pick the expected overflow behaviour.
module tb_m_cycle_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0, fetch = 1'b0, cb_set = 1'b0, dis_cb = 1'b0, halt = 1'b0, wake = 1'b0;
    logic [3:0] step;
    logic [7:0] count;
    logic       cb_act, halted, step_end, wdog;
    logic [15:0] w_obs;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: step index 0..3, M-cycle index 0..7, plus flags.
    int s = 0, c = 0;
    bit hlt = 0, cb = 0, wd = 0;

    m_cycle_sequencer dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall), .i_IR_Fetch(fetch),
        .i_CB_Set(cb_set), .i_Disable_CB(dis_cb), .i_Halt(halt), .i_Wake(wake),
        .o_Cycle_Step(step), .o_Cycle_Count(count), .o_CB_Active(cb_act),
        .o_Halted(halted), .o_Step_End(step_end), .o_Watchdog(wdog)
    );

    always #5 clk = ~clk;

    assign w_obs = {step, count, cb_act, halted, wdog, step_end};

    function automatic logic [15:0] exp_vec();
        logic [3:0] es;
        logic [7:0] ec;
        es = 4'b0001 << s;
        ec = 8'b0000_0001 << c;
        return {es, ec, cb, hlt, wd, (s == 3) && !stall};
    endfunction

    task automatic model_reset();
        s = 0; c = 0; hlt = 0; cb = 0; wd = 0;
    endtask

    task automatic model_clock();
        bit b;
        if (stall) return;
        b = (s == 3);
        s = (s + 1) % 4;
        if (!b) return;
        if (hlt) begin
            c = 0;
            if (wake) hlt = 0;
        end else if (fetch) begin
            c = 0;
            if (cb_set) cb = 1;
            else if (dis_cb) cb = 0;
            if (halt && !wake) hlt = 1;
        end else if (c == 7) begin
            c = 0;
`ifdef CYCLE_WATCHDOG_EN
            cb = 0;
            wd = 1;
`endif
        end else begin
            c = c + 1;
        end
    endtask

    task automatic drive(input logic st, input logic f, input logic cs, input logic d, input logic h, input logic w);
        stall = st; fetch = f; cb_set = cs; dis_cb = d; halt = h; wake = w;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic to_boundary();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4 && s != 3; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (w_obs !== 16'b0001_00000001_0000) $display("FAIL reset: got %h want %h", w_obs, 16'b0001_00000001_0000);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick();
            #1;
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL count[%0d]: got %h want %h", i, w_obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_cb();
        bit [1:0] mode [3] = '{2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 3; k++) begin
            to_boundary();
            drive(0, 1, mode[k][0], mode[k][1], 0, 0);
            for (int i = 0; i < 4; i++) begin
                tick();
                drive(0, 0, 1, 1, 0, 0);
                #1;
                n_chk++;
                if (w_obs !== exp_vec()) $display("FAIL cb[%0d.%0d]: got %h want %h", k, i, w_obs, exp_vec());
                else n_pass++;
            end
        end
        n_chk++;
        if (cb_act !== 1'b1) $display("FAIL cb_set_wins: got %b want 1", cb_act);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 7; i++) begin
            drive(i < 5, 0, 0, 0, 0, 0);
            #1;
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL stall[%0d]: got %h want %h", i, w_obs, exp_vec());
            else n_pass++;
            tick();
        end
        n_chk++;
        if (step !== 4'b0001 || count !== 8'h08) $display("FAIL stall_resume: got %b/%h want 0001/08", step, count);
        else n_pass++;
    endtask

    task automatic test_halt();
        to_boundary();
        drive(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 14; i++) begin
            tick();
            drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 1, (i >= 9));
            #1;
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL halt[%0d]: got %h want %h", i, w_obs, exp_vec());
            else n_pass++;
        end
        to_boundary();
        drive(0, 1, 0, 0, 1, 1);
        tick();
        #1;
        n_chk++;
        if (halted !== 1'b0 || w_obs !== exp_vec()) $display("FAIL halt_wake_same: got %h want %h", w_obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        to_boundary();
        drive(0, 1, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            tick();
            #1;
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL overflow[%0d]: got %h want %h", i, w_obs, exp_vec());
            else n_pass++;
        end
`ifdef CYCLE_WATCHDOG_EN
        n_chk++;
        if (wdog !== 1'b1 || cb_act !== 1'b0 || count !== 8'h01) $display("FAIL overflow_end: got wd=%b cb=%b cnt=%h want 1/0/01", wdog, cb_act, count);
        else n_pass++;
`else
        n_chk++;
        if (wdog !== 1'b0 || cb_act !== 1'b1 || count !== 8'h01) $display("FAIL overflow_end: got wd=%b cb=%b cnt=%h want 0/1/01", wdog, cb_act, count);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 13; i++) tick();
        #1;
        n_chk++;
        if (step !== 4'b0010 || count !== 8'h08) $display("FAIL areset_pre: got %b/%h want 0010/08", step, count);
        else n_pass++;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (w_obs !== 16'b0001_00000001_0000) $display("FAIL areset: got %h want %h", w_obs, 16'b0001_00000001_0000);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        n_chk++;
        if (step !== 4'b0010 || w_obs !== exp_vec()) $display("FAIL areset_release: got %h want %h", w_obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            #1;
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL random[%0d]: got %h want %h", i, w_obs, exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_cb();
        test_stall();
        test_halt();
        test_overflow();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/m_cycle_sequencer.md
# m_cycle_sequencer

Timing generator for the CPU control unit: produces the one-hot T-step (`o_Cycle_Step`) and one-hot M-cycle (`o_Cycle_Count`) vectors consumed by the main and CB-prefix microcode decoders. It also owns the CB-prefix active flag and the HALT state. Instruction boundaries come from the decoders' IR-fetch request, and the bus stall input freezes all timing. It sits between the control-unit top and the microcode ROM/decoder blocks.

## Interface
Parameters: none.
- `i_Clk`  in  1  system clock; all state changes on rising edge
- `i_Reset_n`  in  1  reset, asynchronous, active-low
- `i_Stall`  in  1  bus/DMA wait; freezes step, count, state and flags while high
- `i_IR_Fetch`  in  1  OR of the decoders' IR-fetch outputs; current M-cycle is the last of the instruction
- `i_CB_Set`  in  1  main decoder fetched opcode 0xCB; enter CB mode at next instruction boundary
- `i_Disable_CB`  in  1  CB decoder finished its instruction
- `i_Halt`  in  1  HALT opcode executing
- `i_Wake`  in  1  interrupt pending (IE & IF non-zero)
- `o_Cycle_Step`  out  4  one-hot T-step within the M-cycle
- `o_Cycle_Count`  out  8  one-hot M-cycle index within the instruction
- `o_CB_Active`  out  1  routes control to the CB decoder (its `i_Active`)
- `o_Halted`  out  1  HALT state
- `o_Step_End`  out  1  `o_Cycle_Step[3] & ~i_Stall`; M-cycle boundary strobe
- `o_Watchdog`  out  1  sticky runaway-instruction flag (see Configuration)

## Operation
- Reset values: `o_Cycle_Step` = 4'b0001, `o_Cycle_Count` = 8'b0000_0001, `o_CB_Active` = 0, `o_Halted` = 0, `o_Watchdog` = 0. The state is RUN.
- Step: rotates left by one each unstalled clock (0001→0010→0100→1000→0001).
- Boundary = `o_Step_End`. All inputs except `i_Stall` are sampled only at a boundary and ignored otherwise.
- RUN, at a boundary:
  - `i_IR_Fetch`=1: count ← 0000_0001.
  - `i_IR_Fetch`=0: count shifts left by one.
  - `i_IR_Fetch`=1 and `i_Halt`=1 and `i_Wake`=0: go to HALT.
- HALT:
  - Step keeps rotating. Count is held at 0000_0001 and `o_Halted`=1.
  - At a boundary with `i_Wake`=1: go to RUN, `o_Halted` ← 0. Count stays 0000_0001.
- `i_Halt` and `i_Wake` both high at the same boundary: the halt is ignored and the state remains RUN.
- CB flag (RUN, boundary with `i_IR_Fetch`=1):
  - `i_CB_Set`=1 → set.
  - else `i_Disable_CB`=1 → clear.
  - Set wins if both are high.
  - Never changes mid-M-cycle.
- Count overflow: count is 1000_0000 at a boundary with `i_IR_Fetch`=0. Behaviour is per Configuration.
- `i_Stall` high: every register is held and `o_Step_End`=0. Release resumes exactly at the frozen step.
- Reset asserted mid-instruction: all registers go to their reset values immediately. The first unstalled edge after release advances to step 0010.

## Timing
- Count and CB/HALT changes are registered on the clock edge where `o_Step_End`=1. The new values are visible with step 0001 of the next M-cycle.
- M-cycle = 4 unstalled clocks. An instruction of N M-cycles occupies 4N clocks plus stall clocks.
- `o_Step_End` is combinational from the step register and `i_Stall` (zero-cycle path).
- All other outputs are direct register outputs; there is no combinational input→output path except `o_Step_End`.

## Configuration
- `CYCLE_WATCHDOG_EN` defined:
  - Count overflow forces count ← 0000_0001 and `o_CB_Active` ← 0.
  - It also sets `o_Watchdog`=1, which stays set until reset.
- `CYCLE_WATCHDOG_EN` undefined:
  - Overflow simply rotates count to 0000_0001.
  - `o_CB_Active` is unaffected and `o_Watchdog` is tied 0.

## Test plan
- Reset release, `i_IR_Fetch` held 0 for 3 boundaries → count 01→02→04→08; step period 4 clocks; `o_Step_End` pulses every 4th clock.
- `i_IR_Fetch`=1 with `i_CB_Set`=1 at a boundary → next M-cycle `o_CB_Active`=1, count 0x01. Later `i_IR_Fetch`=1 with `i_Disable_CB`=1 → `o_CB_Active`=0.
- `i_Stall` high for 5 clocks at step 0100, count 0x04 → outputs unchanged for 5 clocks; step 1000 on the first clock after release.
- HALT: `i_IR_Fetch`=`i_Halt`=1 → `o_Halted`=1, count stays 0x01 while step rotates. `i_Wake`=1 mid-M-cycle → exit only at the next boundary. `i_Halt`=`i_Wake`=1 at the same boundary → `o_Halted` stays 0.
- Overflow: 8 boundaries with no fetch while CB active → count 0x80 then 0x01. With the macro: `o_Watchdog`=1 and `o_CB_Active`=0. Without it: `o_Watchdog`=0 and `o_CB_Active`=1.
- `i_Reset_n` low asynchronously at step 0010, count 0x08 → outputs reset values before the next clock edge.
